// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone burst reader.
//   CTI_*       : Wishbone B3 cycle type identifiers
//   BTE_LINEAR  : burst type extension for linear bursts
//   state_t     : burst reader FSM state encoding
//   fifo_cnt_w  : width of a FIFO occupancy counter that can hold 0..depth
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // Pointer width plus one extra bit so the counter can represent "full".
  function automatic int fifo_cnt_w(input int depth);
    return ((depth > 1) ? $clog2(depth) : 1) + 1;
  endfunction

endpackage

// File: rtl/wb_burst_reader_sync_fifo.sv
// Single-clock show-ahead FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata : write one entry (ignored when full)
//   pop        : discard the head entry (ignored when empty)
//   rdata      : head entry, valid whenever valid=1
//   valid      : FIFO non-empty
//   count      : current number of stored entries (0..depth)
module sync_fifo
  import wb_pkg::*;
#(
  parameter int width = 33,
  parameter int depth = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [width-1:0]              wdata,
  input  logic                          pop,
  output logic [width-1:0]              rdata,
  output logic                          valid,
  output logic [fifo_cnt_w(depth)-1:0]  count
);

  localparam int CW = fifo_cnt_w(depth);
  localparam int PW = CW - 1;

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (cnt_q != CW'(depth));
  assign do_pop  = pop && (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PW'(depth - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(depth - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];
  assign valid = (cnt_q != '0);
  assign count = cnt_q;

endmodule

// File: rtl/wb_burst_reader.sv
// Wishbone B3 read initiator: turns a (start address, word count) command
// into linear incrementing read bursts and streams the words out of a FIFO.
//   wb_clk, wb_rst_n        : clock, asynchronous active-low reset
//   cmd_valid/ready/adr/len : command handshake; start byte address, word count
//   done, done_err          : one-cycle completion pulse, error qualifier
//   rd_data/last/valid/ready: read stream (FIFO head), last word of command
//   wb_*                    : Wishbone master read port (all outputs registered)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | ready for a command; zero-length commands complete here
// ST_ISSUE | sizing the next burst, waiting for enough FIFO space
// ST_BURST | cyc/stb asserted, collecting acked beats
module wb_burst_reader
  import wb_pkg::*;
#(
  parameter int adr_width  = 32,
  parameter int len_width  = 16,
  parameter int max_burst  = 8,
  parameter int fifo_depth = 16
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [adr_width-1:0] cmd_adr,
  input  logic [len_width-1:0] cmd_len,
  output logic                 done,
  output logic                 done_err,
  output logic [31:0]          rd_data,
  output logic                 rd_last,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [adr_width-1:0] wb_adr_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [3:0]           wb_sel_o,
  output logic [2:0]           wb_cti_o,
  output logic [1:0]           wb_bte_o,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i
);

  localparam int CW = fifo_cnt_w(fifo_depth);
  localparam logic [adr_width-1:0] ADR_MASK = {{(adr_width-2){1'b1}}, 2'b00};

  state_t               state_q, state_d;
  logic [adr_width-1:0] adr_q, adr_d;
  logic [len_width-1:0] rem_q, rem_d;
  logic [CW-1:0]        beats_q, beats_d;
  logic                 cyc_q, cyc_d;
  logic [2:0]           cti_q, cti_d;
  logic                 done_q, done_d;
  logic                 done_err_q, done_err_d;

  logic                 fifo_push;
  logic [32:0]          fifo_wdata;
  logic [32:0]          fifo_head;
  logic                 fifo_pop;
  logic [CW-1:0]        fifo_count;
  logic [CW-1:0]        free_after;
  logic [CW-1:0]        beats_calc;

  assign fifo_pop = rd_valid && rd_ready;

  // Space that will exist once this cycle's pop has happened. No push can
  // occur outside BURST, so this is exact while in ISSUE.
  assign free_after = CW'(fifo_depth) - fifo_count + CW'(fifo_pop);

  assign beats_calc = (rem_q < len_width'(max_burst)) ? CW'(rem_q) : CW'(max_burst);

  // A word is the last of its command only if it is the very final beat;
  // an error abort never reaches that beat, so no rd_last is produced.
  assign fifo_wdata = {(rem_q == len_width'(1)), wb_dat_i};

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    rem_d      = rem_q;
    beats_d    = beats_q;
    cyc_d      = cyc_q;
    cti_d      = cti_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    fifo_push  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          adr_d = cmd_adr & ADR_MASK;
          rem_d = cmd_len;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        if (free_after >= beats_calc) begin
          beats_d = beats_calc;
          cyc_d   = 1'b1;
          cti_d   = (beats_calc == CW'(1)) ? CTI_CLASSIC : CTI_INCR;
          state_d = ST_BURST;
        end
      end

      ST_BURST: begin
        if (wb_err_i) begin
          cyc_d      = 1'b0;
          cti_d      = CTI_CLASSIC;
          rem_d      = '0;
          beats_d    = '0;
          done_d     = 1'b1;
          done_err_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (wb_ack_i) begin
          fifo_push = 1'b1;
          adr_d     = adr_q + adr_width'(4);
          beats_d   = beats_q - CW'(1);
          rem_d     = rem_q - len_width'(1);
          if (beats_q == CW'(1)) begin
            cyc_d = 1'b0;
            cti_d = CTI_CLASSIC;
            if (rem_q == len_width'(1)) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_ISSUE;
            end
          end else if (beats_q == CW'(2)) begin
            // Next beat presented is the final one of this burst.
            cti_d = CTI_EOB;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q    <= ST_IDLE;
      adr_q      <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      cyc_q      <= 1'b0;
      cti_q      <= CTI_CLASSIC;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      rem_q      <= rem_d;
      beats_q    <= beats_d;
      cyc_q      <= cyc_d;
      cti_q      <= cti_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
    end
  end

  sync_fifo #(
    .width (33),
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (wb_clk),
    .rst_n (wb_rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .valid (rd_valid),
    .count (fifo_count)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = done_q;
  assign done_err  = done_err_q;
  assign rd_data   = fifo_head[31:0];
  assign rd_last   = fifo_head[32];

  assign wb_adr_o  = adr_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = 1'b0;
  assign wb_sel_o  = 4'hF;
  assign wb_cti_o  = cti_q;
  assign wb_bte_o  = BTE_LINEAR;

endmodule
